// File: rtl/conv3x3_mc_stream.sv
// Streaming 3x3 multi-channel FP32 convolution: line buffers + register window,
// per-channel tap sums, cross-channel sum, bias and optional ReLU, fixed-latency output.
module conv3x3_mc_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int CH_IN      = 3,
    parameter int WIDTH      = 32,
    parameter int HEIGHT     = 32,
    parameter int PIPE_LAT   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           w_we,
    input  logic [$clog2(CH_IN*9+1)-1:0]   w_addr,
    input  logic [31:0]                    w_data,
    input  logic                           relu_en,
    input  logic                           i_valid,
    output logic                           i_ready,
    input  logic [DATA_WIDTH*CH_IN-1:0]    i_data,
    output logic                           o_valid,
    output logic [31:0]                    o_data,
    output logic                           o_last,
    output logic                           busy,
    output logic                           w_err
);
    localparam int NW = CH_IN*9+1;
    localparam int AW = $clog2(NW);
    localparam int PW = DATA_WIDTH*CH_IN;
    localparam int NP = PIPE_LAT-1;
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic s, g, st;
        logic [7:0] ea, eb;
        logic [47:0] p;
        logic [23:0] m;
        logic [24:0] mr;
        logic signed [10:0] e;
        s = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        if (ea == 8'hFF && a[22:0] != '0) return a | 32'h0040_0000;
        if (eb == 8'hFF && b[22:0] != '0) return b | 32'h0040_0000;
        if (ea == 8'hFF || eb == 8'hFF) return (ea == 8'h00 || eb == 8'h00) ? QNAN : {s, 8'hFF, 23'h0};
        if (ea == 8'h00 || eb == 8'h00) return {s, 31'h0};
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127;
        if (p[47]) begin
            m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 11'sd1;
        end else begin
            m = p[46:23]; g = p[22]; st = |p[21:0];
        end
        mr = {1'b0, m} + 25'(g & (st | m[0]));
        if (mr[24]) begin
            mr = mr >> 1; e = e + 11'sd1;
        end
        if (e >= 11'sd255) return {s, 8'hFF, 23'h0};
        if (e <= 11'sd0) return '0;
        return {s, e[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a, b, t;
        logic [26:0] am, bm;
        logic [27:0] s;
        logic [24:0] mr;
        logic [7:0] d;
        logic signed [10:0] e;
        a = a_in;
        b = b_in;
        if (a[30:23] == 8'hFF && a[22:0] != '0) return a | 32'h0040_0000;
        if (b[30:23] == 8'hFF && b[22:0] != '0) return b | 32'h0040_0000;
        if (a[30:23] == 8'hFF) return (b[30:23] == 8'hFF && a[31] != b[31]) ? QNAN : a;
        if (b[30:23] == 8'hFF) return b;
        // Denormals collapse to zero; only a true -0 keeps its sign.
        if (a[30:23] == 8'h00) a = {a[31] & (a[22:0] == '0), 31'h0};
        if (b[30:23] == 8'h00) b = {b[31] & (b[22:0] == '0), 31'h0};
        if (a[30:0] == '0) return (b[30:0] == '0) ? {a[31] & b[31], 31'h0} : b;
        if (b[30:0] == '0) return a;
        if (a[30:0] < b[30:0]) begin
            t = a; a = b; b = t;
        end
        d = a[30:23] - b[30:23];
        am = {1'b1, a[22:0], 3'b000};
        bm = {1'b1, b[22:0], 3'b000};
        if (d > 8'd26) bm = 27'd1;
        else bm = (bm >> d) | 27'(|(bm & ~({27{1'b1}} << d)));
        e = $signed({3'b000, a[30:23]});
        if (a[31] == b[31]) begin
            s = {1'b0, am} + {1'b0, bm};
            if (s[27]) begin
                s = {1'b0, s[27:2], s[1] | s[0]}; e = e + 11'sd1;
            end
        end else begin
            s = {1'b0, am} - {1'b0, bm};
            if (s == '0) return '0;
            for (int unsigned i = 0; i < 26; i++) begin
                if (!s[26]) begin
                    s = s << 1; e = e - 11'sd1;
                end
            end
        end
        mr = {1'b0, s[26:3]} + 25'(s[2] & (s[1] | s[0] | s[3]));
        if (mr[24]) begin
            mr = mr >> 1; e = e + 11'sd1;
        end
        if (e >= 11'sd255) return {a[31], 8'hFF, 23'h0};
        if (e <= 11'sd0) return '0;
        return {a[31], e[7:0], mr[22:0]};
    endfunction

    logic [31:0]   wt [NW];
    logic [PW-1:0] lb0 [WIDTH];
    logic [PW-1:0] lb1 [WIDTH];
    logic [PW-1:0] win [3][3];
    logic [31:0]   pd [NP];
    logic [NP-1:0] pv, pl;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          rdy_q, go, go_last, relu_q, pend, accept, in_rng, last_pos;
    logic [31:0]   y, sk, prod;

    assign i_ready  = rdy_q & ~w_we;
    assign accept   = i_valid & i_ready;
    assign in_rng   = ({1'b0, w_addr} < (AW+1)'(NW));
    assign last_pos = (col == CW'(WIDTH-1)) && (row == RW'(HEIGHT-1));
    assign o_valid  = pv[NP-1];
    assign o_last   = pl[NP-1];
    assign o_data   = pd[NP-1];

    always_comb begin
        y = '0;
        sk = '0;
        prod = '0;
        for (int unsigned k = 0; k < CH_IN; k++) begin
            for (int unsigned t = 0; t < 9; t++) begin
                prod = fp_mul(wt[k*9+t], win[t/3][t%3][k*32 +: 32]);
                sk = (t == 0) ? prod : fp_add(sk, prod);
            end
            y = (k == 0) ? sk : fp_add(y, sk);
        end
        y = fp_add(y, wt[NW-1]);
        if (relu_q && y[31]) y = '0;
    end

    // A frame is still pending if beats are mid-raster or a frame-final result
    // sits anywhere upstream of the output stage.
    always_comb begin
        pend = go_last | accept | (col != '0) | (row != '0);
        for (int unsigned i = 0; i < NP-1; i++) pend = pend | pl[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q   <= 1'b0;
            col     <= '0;
            row     <= '0;
            go      <= 1'b0;
            go_last <= 1'b0;
            relu_q  <= 1'b0;
            busy    <= 1'b0;
            w_err   <= 1'b0;
            pv      <= '0;
            pl      <= '0;
            for (int unsigned i = 0; i < NW; i++) wt[i] <= '0;
        end else begin
            rdy_q   <= 1'b1;
            go      <= accept && (row >= RW'(2)) && (col >= CW'(2));
            go_last <= accept && last_pos;
            busy    <= pend;
            pv      <= {pv[NP-1:0], go} >> 0;
            pl      <= {pl[NP-1:0], go_last} >> 0;
            if (accept) begin
                if (col == '0 && row == '0) relu_q <= relu_en;
                if (col == CW'(WIDTH-1)) begin
                    col <= '0;
                    row <= (row == RW'(HEIGHT-1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (w_we && in_rng) begin
                if (busy) w_err <= 1'b1;
                else wt[w_addr] <= w_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        pd[0] <= y;
        for (int unsigned i = 1; i < NP; i++) pd[i] <= pd[i-1];
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= i_data;
            for (int unsigned j = 0; j < 3; j++) begin
                win[j][0] <= win[j][1];
                win[j][1] <= win[j][2];
            end
            win[0][2] <= lb1[col];
            win[1][2] <= lb0[col];
            win[2][2] <= i_data;
        end
    end
endmodule

// File: tb/tb_conv3x3_mc_stream.sv
// Self-checking bench for conv3x3_mc_stream: table-driven frames plus corner-case
// sequences, with a scoreboard queue checking value, o_last and exact latency.
module tb_conv3x3_mc_stream;
    localparam int CH = 3, W = 5, H = 5, LAT = 8;
    localparam logic [31:0] ONE = 32'h3F80_0000, MONE = 32'hBF80_0000;
    localparam logic [31:0] HALF = 32'h3F00_0000, TWO = 32'h4000_0000;

    logic clk = 1'b0, rst = 1'b1, w_we = 1'b0, relu_en = 1'b0, i_valid = 1'b0;
    logic [4:0] w_addr = '0;
    logic [31:0] w_data = '0;
    logic [32*CH-1:0] i_data = '0;
    logic i_ready, o_valid, o_last, busy, w_err;
    logic [31:0] o_data;

    conv3x3_mc_stream #(.DATA_WIDTH(32), .CH_IN(CH), .WIDTH(W), .HEIGHT(H), .PIPE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .relu_en(relu_en), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .busy(busy), .w_err(w_err));

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic last; int due; } exp_t;
    typedef struct { logic [31:0] wval; logic [31:0] bias; logic centre; logic relu; int gap;
                     logic [31:0] expv; string name; } vec_t;

    exp_t q[$];
    vec_t vecs[5];
    int cyc = 0, n_checks = 0, n_fail = 0, n_out = 0, drops = 0;
    logic prev_busy = 1'b0, cur_centre = 1'b0;
    logic [31:0] cur_expv = '0;

    always @(posedge clk) cyc = cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic logic [31:0] int2fp(input int v);
        int m = 0;
        logic [31:0] u;
        if (v == 0) return '0;
        for (int i = 0; i < 24; i++) if (v[i]) m = i;
        u = 32'(v) << (23 - m);
        return {1'b0, 8'(127 + m), u[22:0]};
    endfunction

    function automatic vec_t mk(input logic [31:0] wv, input logic [31:0] bs, input logic cn,
                                input logic rl, input int gp, input logic [31:0] ev, input string nm);
        vec_t v;
        v.wval = wv; v.bias = bs; v.centre = cn; v.relu = rl; v.gap = gp; v.expv = ev; v.name = nm;
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) drops++;
            prev_busy = busy;
            if (o_valid) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("unexpected_o_valid", 32'(o_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("o_data", o_data, e.data);
                    chk("o_last", 32'(o_last), 32'(e.last));
                    chk("latency", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        i_valid = 1'b0;
        w_we = 1'b0;
        #1;
        while ((busy || q.size() != 0) && k < 300) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 300) begin
            chk("idle_timeout_busy", 32'(busy), 32'd0);
            chk("idle_timeout_queue", 32'(q.size()), 32'd0);
        end
    endtask

    task automatic write_w(input int a, input logic [31:0] d);
        @(negedge clk);
        w_we = 1'b1;
        w_addr = 5'(a);
        w_data = d;
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic load_weights(input logic [31:0] wv, input logic [31:0] bs, input logic cn);
        for (int a = 0; a < CH*9+1; a++) begin
            @(negedge clk);
            w_we = 1'b1;
            w_addr = 5'(a);
            w_data = (a == CH*9) ? bs : (cn ? ((a == 4) ? ONE : 32'h0) : wv);
        end
        @(negedge clk);
        w_we = 1'b0;
    endtask

    task automatic drive_frame(input int gap, input int wr_at, input int stop_at, input bit flip);
        int n = 0, r = 0, c = 0, spin = 0;
        bit wr_done = 0, flip_pend = 0;
        exp_t e;
        while (n < W*H && n != stop_at && spin < 2000) begin
            @(negedge clk);
            spin++;
            if (flip_pend) begin
                relu_en = ~relu_en;
                flip_pend = 0;
            end
            r = n / W;
            c = n % W;
            w_we = (n == wr_at) && !wr_done;
            if (w_we) begin
                w_addr = '0;
                w_data = TWO;
                wr_done = 1;
            end
            i_valid = (gap == 0) || ($urandom_range(99) >= 32'(gap));
            i_data = cur_centre ? {ONE, ONE, int2fp(r*W + c)} : {ONE, ONE, ONE};
            #1;
            if (w_we) chk("i_ready_during_write", 32'(i_ready), 32'd0);
            if (i_valid && i_ready) begin
                if (r >= 2 && c >= 2) begin
                    e.data = cur_centre ? int2fp((r-1)*W + (c-1)) : cur_expv;
                    e.last = (r == H-1) && (c == W-1);
                    e.due = cyc + LAT;
                    q.push_back(e);
                end
                if (n == 0 && flip) flip_pend = 1;
                n++;
            end
        end
        if (spin >= 2000) chk("frame_timeout", 32'(n), 32'(W*H));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, d0;
        vecs[0] = mk(ONE,  32'h0, 1'b0, 1'b0, 0,  32'h41D8_0000, "ones");
        vecs[1] = mk(MONE, HALF,  1'b0, 1'b0, 0,  32'hC1D4_0000, "neg_bias");
        vecs[2] = mk(MONE, HALF,  1'b0, 1'b1, 0,  32'h0000_0000, "neg_relu");
        vecs[3] = mk(32'h0, 32'h0, 1'b1, 1'b0, 0, 32'h0000_0000, "centre");
        vecs[4] = mk(ONE,  32'h0, 1'b0, 1'b0, 50, 32'h41D8_0000, "ones_gaps");

        repeat (2) @(negedge clk);
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_w_err", 32'(w_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("i_ready_after_rst", 32'(i_ready), 32'd1);

        foreach (vecs[i]) begin
            wait_idle();
            relu_en = vecs[i].relu;
            cur_centre = vecs[i].centre;
            cur_expv = vecs[i].expv;
            load_weights(vecs[i].wval, vecs[i].bias, vecs[i].centre);
            n0 = n_out;
            drive_frame(vecs[i].gap, -1, -1, 1'b0);
            wait_idle();
            chk({"count_", vecs[i].name}, 32'(n_out - n0), 32'd9);
        end

        // Back-to-back frames: busy must stay high across the boundary.
        d0 = drops;
        n0 = n_out;
        drive_frame(0, -1, -1, 1'b0);
        drive_frame(0, -1, -1, 1'b0);
        wait_idle();
        chk("b2b_busy_falls", 32'(drops - d0), 32'd1);
        chk("b2b_count", 32'(n_out - n0), 32'd18);

        // relu_en flipped after the first beat must not affect this frame.
        load_weights(MONE, HALF, 1'b0);
        relu_en = 1'b0;
        cur_expv = 32'hC1D4_0000;
        drive_frame(0, -1, -1, 1'b1);
        wait_idle();

        // Write while busy: ignored, sticky w_err; write while idle takes effect.
        load_weights(ONE, 32'h0, 1'b0);
        cur_expv = 32'h41D8_0000;
        chk("w_err_before", 32'(w_err), 32'd0);
        drive_frame(0, 10, -1, 1'b0);
        wait_idle();
        chk("w_err_set", 32'(w_err), 32'd1);
        drive_frame(0, -1, -1, 1'b0);
        wait_idle();
        write_w(0, TWO);
        cur_expv = 32'h41E0_0000;
        drive_frame(0, -1, -1, 1'b0);
        wait_idle();
        chk("w_err_sticky", 32'(w_err), 32'd1);

        // Reset mid-frame with results in flight.
        cur_expv = 32'h41E0_0000;
        drive_frame(0, -1, 14, 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        rst = 1'b1;
        #1;
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("w_err_cleared", 32'(w_err), 32'd0);
        cur_expv = 32'h0;
        n0 = n_out;
        drive_frame(0, -1, -1, 1'b0);
        wait_idle();
        repeat (LAT + 2) @(negedge clk);
        chk("post_rst_count", 32'(n_out - n0), 32'd9);
        chk("final_queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
